// File: rtl/bram_tap_window.sv
// bram_tap_window: captures BRAM read data (doutb) into a DEPTH-tap sliding window,
// delaying rd_en by RD_LAT cycles so capture lines up with valid read data.
// Tracks per-tap validity and fill level, and pulses win_vld whenever a capture
// leaves the window full.
module bram_tap_window #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 4,
  parameter  int RD_LAT = 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                   readclk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       doutb,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       tap_vld,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full,
  output logic                   win_vld
);

  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic             cap;
  logic [WIDTH-1:0] tap_q [DEPTH];
  logic [CW-1:0]    fill_inc;
  logic             fill_inc_full;

  if (RD_LAT == 0) begin : g_no_lat
    assign cap = rd_en;
  end else begin : g_lat
    logic [RD_LAT-1:0] pipe;

    // Delay rd_en by RD_LAT cycles; a flush drops every read still in flight.
    always_ff @(posedge readclk or posedge reset) begin
      if (reset) begin
        pipe <= '0;
      end else if (flush) begin
        pipe <= '0;
      end else begin
        pipe[0] <= rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign cap = pipe[RD_LAT-1];
  end

  // Saturating fill increment; the count never wraps past DEPTH.
  always_comb begin
    fill_inc      = (fill_cnt == FullCnt) ? fill_cnt : fill_cnt + CW'(1);
    fill_inc_full = (fill_inc == FullCnt);
  end

  // Window state: flush beats capture; oldest tap falls off the end when full.
  always_ff @(posedge readclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
      tap_vld  <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
      win_vld  <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        tap_q[k] <= '0;
      end
      tap_vld  <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
      win_vld  <= 1'b0;
    end else if (cap) begin
      tap_q[0] <= doutb;
      for (int k = 1; k < DEPTH; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
      tap_vld  <= {tap_vld[DEPTH-2:0], 1'b1};
      fill_cnt <= fill_inc;
      full     <= fill_inc_full;
      win_vld  <= fill_inc_full;
    end else begin
      win_vld <= 1'b0;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*WIDTH +: WIDTH] = tap_q[k];
  end

endmodule
